// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl_if
//  Description : Bundle of the display-scan signals between the pixel clock,
//                the datapath result register and the 8-digit seven-segment
//                pins.
//                master : drives pix_clk/data/dp/blank and observes the pins
//                slave  : the scan controller
//  Ports       : pix_clk (1), data_in (32), dp_in (8), blank_in (8)  -> slave
//                anode_n (8), cathode_n (7), dp_n (1), frame_start (1) <- slave
//  Revision    : 1.0  initial release
// ============================================================================
interface seg_scan_ctrl_if;
    logic        pix_clk;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
    logic [7:0]  anode_n;
    logic [6:0]  cathode_n;
    logic        dp_n;
    logic        frame_start;

    modport master (
        output pix_clk, data_in, dp_in, blank_in,
        input  anode_n, cathode_n, dp_n, frame_start
    );

    modport slave (
        input  pix_clk, data_in, dp_in, blank_in,
        output anode_n, cathode_n, dp_n, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexes a 32-bit hex value onto an eight-digit
//                seven-segment display, advancing one digit per rising edge
//                of the (asynchronous, slow) pix_clk refresh signal.
//                pix_clk is synchronised and edge-detected, never used as a
//                clock. A snapshot of data/dp/blank is taken at each frame
//                start so a frame never tears.
//  Ports       : clk_in      in   board clock, all flops on its rising edge
//                reset       in   asynchronous active-high reset
//                bus         slave modport of seg_scan_ctrl_if
//                  pix_clk, data_in[31:0], dp_in[7:0], blank_in[7:0] (in)
//                  anode_n[7:0], cathode_n[6:0], dp_n, frame_start   (out)
//  Parameters  : NUM_DIGITS  1..8  digits scanned (upper anodes stay off)
//                SYNC_STAGES 2..3  synchroniser depth for pix_clk
//  Options     : LEADING_ZERO_BLANK_EN - blank leading-zero digits above the
//                most significant nonzero nibble (unless their dp is lit)
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic     clk_in,
    input  wire logic     reset,
    seg_scan_ctrl_if.slave bus
);

    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    // Synchroniser, edge-detect delay flop and scan counter
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   delay_q, delay_d;
    logic [2:0]             digit_q, digit_d;

    // Frame snapshot
    logic [31:0] shadow_data_q, shadow_data_d;
    logic [7:0]  shadow_dp_q, shadow_dp_d;
    logic [7:0]  shadow_blank_q, shadow_blank_d;

    // Registered pin drivers
    logic [7:0] anode_q, anode_d;
    logic [6:0] cathode_q, cathode_d;
    logic       dp_q, dp_d;
    logic       frame_q, frame_d;

    logic       strobe;
    logic [2:0] nxt;
    logic       wrap;
    logic [7:0] new_blank;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;  4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;  default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A digit above the most significant nonzero nibble is a leading zero:
    // walking down from the top, it stays blank while every nibble seen so
    // far (itself included) is zero. Digit 0 is never considered.
    logic [7:0] lz_mask;
    logic       run_zero;

    always_comb begin
        lz_mask  = '0;
        run_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run_zero   = run_zero & (bus.data_in[4*k +: 4] == 4'h0);
            lz_mask[k] = run_zero & ~bus.dp_in[k];
        end
    end

    assign new_blank = bus.blank_in | lz_mask;
`else
    assign new_blank = bus.blank_in;
`endif

    assign strobe = sync_q[SYNC_STAGES-1] & ~delay_q;
    assign nxt    = (digit_q == LAST_DIGIT) ? 3'd0 : digit_q + 3'd1;
    assign wrap   = strobe && (nxt == 3'd0);

    always_comb begin
        logic [31:0] sel_data;
        logic [7:0]  sel_dp;
        logic [7:0]  sel_blank;

        sync_d         = {sync_q[SYNC_STAGES-2:0], bus.pix_clk};
        delay_d        = sync_q[SYNC_STAGES-1];
        digit_d        = digit_q;
        shadow_data_d  = shadow_data_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        anode_d        = anode_q;
        cathode_d      = cathode_q;
        dp_d           = dp_q;
        frame_d        = 1'b0;

        // Digit 0 of a new frame is drawn from the values being captured
        // this very cycle, not from the stale snapshot.
        sel_data  = wrap ? bus.data_in : shadow_data_q;
        sel_dp    = wrap ? bus.dp_in   : shadow_dp_q;
        sel_blank = wrap ? new_blank   : shadow_blank_q;

        if (wrap) begin
            shadow_data_d  = bus.data_in;
            shadow_dp_d    = bus.dp_in;
            shadow_blank_d = new_blank;
            frame_d        = 1'b1;
        end

        if (strobe) begin
            digit_d   = nxt;
            anode_d   = sel_blank[nxt] ? 8'hFF : ~(8'b1 << nxt);
            cathode_d = hex7(sel_data[{nxt, 2'b00} +: 4]);
            dp_d      = ~sel_dp[nxt];
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q         <= '0;
            delay_q        <= 1'b0;
            digit_q        <= LAST_DIGIT;   // first strobe wraps to digit 0
            shadow_data_q  <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            anode_q        <= 8'hFF;
            cathode_q      <= 7'h7F;
            dp_q           <= 1'b1;
            frame_q        <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            delay_q        <= delay_d;
            digit_q        <= digit_d;
            shadow_data_q  <= shadow_data_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            anode_q        <= anode_d;
            cathode_q      <= cathode_d;
            dp_q           <= dp_d;
            frame_q        <= frame_d;
        end
    end

    assign bus.anode_n     = anode_q;
    assign bus.cathode_n   = cathode_q;
    assign bus.dp_n        = dp_q;
    assign bus.frame_start = frame_q;

endmodule
`default_nettype wire
